// File: rtl/stupid_toy_pkg.sv
// Shared types for the toy byte sender: FSM state encoding and byte width.
package stupid_toy_pkg;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_e;
endpackage

// File: rtl/stupid_toy_fifo.sv
// Small synchronous FIFO; push while full and pop while empty are dropped.
// next_head_o exposes the entry behind the head so the sender can chain strobes.
module stupid_toy_fifo #(
   parameter int DEPTH  = 4,
   parameter int BYTE_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [BYTE_W-1:0]       data_i,
   input  logic                    pop_i,
   output logic [BYTE_W-1:0]       head_o,
   output logic [BYTE_W-1:0]       next_head_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o,
   output logic                    empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     rd_q, wr_q, rd_nx;
   logic [AW:0]       cnt_q;
   logic              do_push, do_pop;

   assign full_o      = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o     = (cnt_q == '0);
   assign do_push     = push_i && !full_o;
   assign do_pop      = pop_i && !empty_o;
   assign rd_nx       = rd_q + AW'(1);
   assign head_o      = mem_q[rd_q];
   assign next_head_o = mem_q[rd_nx];
   assign count_o     = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_nx;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/stupid_toy_sender.sv
// Byte-load transmitter: queues upstream bytes and emits each as a one-cycle
// load_enable strobe, with a programmable gap and an optional sticky byte limit.
module stupid_toy_sender
   import stupid_toy_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 1,
   parameter int MAX_BYTES  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BYTE_W-1:0] data,
   output logic              load_enable,
   output logic              busy,
   output logic              done,
   output logic [7:0]        sent_count
);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   state_e            state_q;
   logic [GW-1:0]     gap_q;
   logic [BYTE_W-1:0] data_q;
   logic              le_q;
   logic [7:0]        sent_q;

   logic [BYTE_W-1:0] head, nhead, nxt_byte;
   logic [CW-1:0]     fcount;
   logic              full, empty, push, pop, more, hit;
   logic [7:0]        sent_inc;

   assign in_ready = !reset && !full && (state_q != DONE);
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == SEND);

   stupid_toy_fifo #(.DEPTH(DEPTH), .BYTE_W(BYTE_W)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .data_i     (in_data),
      .pop_i      (pop),
      .head_o     (head),
      .next_head_o(nhead),
      .count_o    (fcount),
      .full_o     (full),
      .empty_o    (empty)
   );

   // Back-to-back chaining looks past the popped head, including a byte
   // arriving in the same cycle when the FIFO is about to run dry.
   assign more     = (fcount > CW'(1)) || push;
   assign nxt_byte = (fcount > CW'(1)) ? nhead : in_data;
   assign sent_inc = (sent_q == 8'hFF) ? sent_q : sent_q + 8'd1;
   assign hit      = (MAX_BYTES != 0) && (int'(sent_q) + 1 == MAX_BYTES);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gap_q   <= '0;
         data_q  <= '0;
         le_q    <= 1'b0;
         sent_q  <= '0;
      end else begin
         le_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  state_q <= SEND;
                  le_q    <= 1'b1;
                  data_q  <= head;
               end
            end
            SEND: begin
               sent_q <= sent_inc;
               if (hit) begin
                  state_q <= DONE;
               end else if (GAP_CYCLES > 0) begin
                  state_q <= GAP;
                  gap_q   <= GW'(GAP_CYCLES - 1);
               end else if (more) begin
                  state_q <= SEND;
                  le_q    <= 1'b1;
                  data_q  <= nxt_byte;
               end else begin
                  state_q <= IDLE;
               end
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - GW'(1);
               end else if (!empty) begin
                  state_q <= SEND;
                  le_q    <= 1'b1;
                  data_q  <= head;
               end else begin
                  state_q <= IDLE;
               end
            end
            DONE: ;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data        = data_q;
   assign load_enable = le_q;
   assign done        = (state_q == DONE);
   assign busy        = (state_q != DONE) && (!empty || (state_q != IDLE));
   assign sent_count  = sent_q;
endmodule

// File: tb/tb_stupid_toy_sender.sv
// Three senders (no gap / gap 2 / gap 1 with limit 2) share one stimulus stream;
// each is scored against a strobe-timing model, plus directed tables and sequences.
module tb_stupid_toy_sender;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst, vin;
   logic [7:0] din;
   logic [2:0] rdy, le, bsy, dn;
   logic [2:0][7:0] dout, cnt;

   always #5 clk = ~clk;

   stupid_toy_sender #(.DEPTH(DEPTH), .GAP_CYCLES(0), .MAX_BYTES(0)) u_a (
      .clk(clk), .reset(rst), .in_data(din), .in_valid(vin), .in_ready(rdy[0]),
      .data(dout[0]), .load_enable(le[0]), .busy(bsy[0]), .done(dn[0]), .sent_count(cnt[0]));
   stupid_toy_sender #(.DEPTH(DEPTH), .GAP_CYCLES(2), .MAX_BYTES(0)) u_b (
      .clk(clk), .reset(rst), .in_data(din), .in_valid(vin), .in_ready(rdy[1]),
      .data(dout[1]), .load_enable(le[1]), .busy(bsy[1]), .done(dn[1]), .sent_count(cnt[1]));
   stupid_toy_sender #(.DEPTH(DEPTH), .GAP_CYCLES(1), .MAX_BYTES(2)) u_c (
      .clk(clk), .reset(rst), .in_data(din), .in_valid(vin), .in_ready(rdy[2]),
      .data(dout[2]), .load_enable(le[2]), .busy(bsy[2]), .done(dn[2]), .sent_count(cnt[2]));

   int checks, failures, cyc;
   int gp[3], mx[3];
   bit prev_rst;

   // Reference: each queued byte carries the earliest cycle it may be strobed.
   logic [7:0] qd[3][64];
   int qr[3][64];
   int qh[3], qt[3], last_s[3], nsent[3];
   logic [7:0] lastd[3];

   // Observed strobes, for the directed ordering/spacing checks.
   int slog_c[3][256];
   logic [7:0] slog_d[3][256];
   int sn[3];

   typedef struct {
      bit v; logic [7:0] d;
      bit le; logic [7:0] dat; bit rdy; bit bsy; logic [7:0] cnt;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, want);
      end
   endtask

   task automatic model_reset(input int i);
      qh[i] = 0; qt[i] = 0; nsent[i] = 0; last_s[i] = -1000; lastd[i] = 8'h00;
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 3; i++) sn[i] = 0;
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit r);
      for (int i = 0; i < 3; i++) begin
         int sz, hd;
         bit dn_e, rdy_e, s, bz;
         logic [7:0] de;
         sz    = qt[i] - qh[i];
         hd    = qh[i] % 64;
         dn_e  = (mx[i] != 0) && (nsent[i] == mx[i]);
         rdy_e = !dn_e && (sz < DEPTH);
         s     = !dn_e && (sz > 0) && (cyc >= qr[i][hd]) && (cyc >= last_s[i] + gp[i] + 1);
         de    = s ? qd[i][hd] : lastd[i];
         bz    = !dn_e && ((sz > 0) || (cyc > last_s[i] && cyc <= last_s[i] + gp[i]));
         chk($sformatf("dut%0d load_enable @%0d", i, cyc), int'(le[i]), int'(s));
         chk($sformatf("dut%0d data @%0d", i, cyc), int'(dout[i]), int'(de));
         chk($sformatf("dut%0d busy @%0d", i, cyc), int'(bsy[i]), int'(bz));
         chk($sformatf("dut%0d done @%0d", i, cyc), int'(dn[i]), int'(dn_e));
         chk($sformatf("dut%0d sent_count @%0d", i, cyc), int'(cnt[i]), (nsent[i] > 255) ? 255 : nsent[i]);
         chk($sformatf("dut%0d in_ready @%0d", i, cyc), int'(rdy[i]), prev_rst ? 0 : int'(rdy_e));
         if (le[i] && sn[i] < 256) begin
            slog_c[i][sn[i]] = cyc;
            slog_d[i][sn[i]] = dout[i];
            sn[i]++;
         end
         if (r) begin
            model_reset(i);
         end else begin
            if (s) begin
               qh[i]++; last_s[i] = cyc; nsent[i]++; lastd[i] = de;
            end
            if (v && rdy_e) begin
               qd[i][qt[i] % 64] = d;
               qr[i][qt[i] % 64] = (gp[i] == 0 && last_s[i] == cyc) ? cyc + 1 : cyc + 2;
               qt[i]++;
            end
         end
      end
      prev_rst = r; rst = r; vin = v; din = d;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      clear_logs();
   endtask

   task automatic chk_tbl(input int k);
      chk($sformatf("tbl%0d load_enable", k), int'(le[0]), int'(tbl[k].le));
      chk($sformatf("tbl%0d data", k), int'(dout[0]), int'(tbl[k].dat));
      chk($sformatf("tbl%0d in_ready", k), int'(rdy[0]), int'(tbl[k].rdy));
      chk($sformatf("tbl%0d busy", k), int'(bsy[0]), int'(tbl[k].bsy));
      chk($sformatf("tbl%0d sent_count", k), int'(cnt[0]), int'(tbl[k].cnt));
   endtask

   initial begin
      logic [7:0] stall_b [6];
      int k, guard;
      bit saw_low;
      checks = 0; failures = 0; cyc = 0; prev_rst = 1'b1;
      rst = 1'b1; vin = 1'b0; din = 8'h00;
      gp = '{0, 2, 1};
      mx = '{0, 0, 2};
      for (int i = 0; i < 3; i++) model_reset(i);
      clear_logs();

      // Expected state of the no-gap sender after each row's clock edge.
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 8'd0};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 8'd0};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1};
      tbl[3] = '{1'b1, 8'h01, 1'b0, 8'hA5, 1'b1, 1'b1, 8'd1};
      tbl[4] = '{1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 1'b1, 8'd1};
      tbl[5] = '{1'b1, 8'h03, 1'b1, 8'h02, 1'b1, 1'b1, 8'd2};
      tbl[6] = '{1'b1, 8'h04, 1'b1, 8'h03, 1'b1, 1'b1, 8'd3};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 1'b1, 8'd4};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 8'd5};

      repeat (2) @(posedge clk);
      @(negedge clk);

      do_reset();
      for (int r = 0; r < 9; r++) begin
         step(tbl[r].v, tbl[r].d, 1'b0);
         chk_tbl(r);
      end

      // Gap of 2: strobes exactly three cycles apart, in order.
      do_reset();
      step(1'b1, 8'h10, 1'b0); step(1'b1, 8'h20, 1'b0); step(1'b1, 8'h30, 1'b0);
      repeat (12) step(1'b0, 8'h00, 1'b0);
      chk("gap strobe count", sn[1], 3);
      chk("gap byte0", int'(slog_d[1][0]), 'h10);
      chk("gap byte1", int'(slog_d[1][1]), 'h20);
      chk("gap byte2", int'(slog_d[1][2]), 'h30);
      chk("gap spacing01", slog_c[1][1] - slog_c[1][0], 3);
      chk("gap spacing12", slog_c[1][2] - slog_c[1][1], 3);

      // Output stalled by the gap: FIFO fills, pointers wrap, nothing lost.
      do_reset();
      stall_b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
      k = 0; guard = 0; saw_low = 1'b0;
      while (k < 6 && guard < 100) begin
         bit acc;
         acc = rdy[1];
         if (!rdy[1]) saw_low = 1'b1;
         step(1'b1, stall_b[k], 1'b0);
         if (acc) k++;
         guard++;
      end
      chk("stall push timeout", k, 6);
      chk("stall in_ready low seen", int'(saw_low), 1);
      repeat (30) step(1'b0, 8'h00, 1'b0);
      chk("stall strobe count", sn[1], 6);
      for (int j = 0; j < 6; j++)
         chk($sformatf("stall order %0d", j), int'(slog_d[1][j]), int'(stall_b[j]));

      // Byte limit of 2: third byte stays queued, sender goes sticky-done.
      do_reset();
      step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h22, 1'b0); step(1'b1, 8'h33, 1'b0);
      repeat (15) step(1'b0, 8'h00, 1'b0);
      chk("limit strobe count", sn[2], 2);
      chk("limit byte0", int'(slog_d[2][0]), 'h11);
      chk("limit byte1", int'(slog_d[2][1]), 'h22);
      chk("limit done", int'(dn[2]), 1);
      chk("limit in_ready", int'(rdy[2]), 0);
      chk("limit busy", int'(bsy[2]), 0);
      chk("limit sent_count", int'(cnt[2]), 2);

      // Reset during a gap with two bytes queued.
      do_reset();
      step(1'b1, 8'h40, 1'b0); step(1'b1, 8'h50, 1'b0); step(1'b1, 8'h60, 1'b0);
      chk("midgap busy", int'(bsy[1]), 1);
      chk("midgap strobe seen", sn[1], 1);
      step(1'b0, 8'h00, 1'b1);
      chk("midgap rst load_enable", int'(le[1]), 0);
      chk("midgap rst data", int'(dout[1]), 0);
      chk("midgap rst busy", int'(bsy[1]), 0);
      chk("midgap rst done", int'(dn[1]), 0);
      chk("midgap rst sent_count", int'(cnt[1]), 0);
      chk("midgap rst in_ready", int'(rdy[1]), 0);
      clear_logs();
      repeat (9) step(1'b0, 8'h00, 1'b0);
      chk("midgap no stale strobe", sn[1], 0);
      step(1'b1, 8'h77, 1'b0);
      repeat (6) step(1'b0, 8'h00, 1'b0);
      chk("midgap new strobe count", sn[1], 1);
      chk("midgap new byte", int'(slog_d[1][0]), 'h77);

      // Random traffic with occasional resets, scored by the model.
      for (int rnd = 0; rnd < 4; rnd++) begin
         do_reset();
         repeat (300) begin
            bit v, r;
            logic [7:0] d;
            v = ($urandom_range(0, 99) < 60);
            d = 8'($urandom);
            r = ($urandom_range(0, 199) == 0);
            step(v, d, r);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
